pixel_write_arbiter: RTL and testbench

Shares the single framebuffer pixel write port between NUM_REQ pixel drawers, e.g. the wave drawer (draw/erase sweeps) and an overlay/axis drawer. Arbitration is round-robin. An owner may hold the grant for a bounded burst of consecutive writes. The block sits between the drawer datapaths and the VGA framebuffer write interface.

---
 rtl/pixel_arb_pkg.sv | 18 +
 rtl/pixel_write_arbiter_rr_picker.sv | 32 +++
 rtl/pixel_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the pixel write arbiter.
package pixel_arb_pkg;

  // Arbiter FSM: IDLE has no owner, BUSY has exactly one owner.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Default framebuffer geometry: 640x480, monochrome.
  localparam int DEF_X_W     = 10;
  localparam int DEF_Y_W     = 9;
  localparam int DEF_COLOR_W = 1;

  // Width of each per-requester accepted-write statistics counter.
  localparam int STAT_W = 16;

endpackage

// File: rtl/pixel_write_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Outputs one-hot winner, its index and a valid flag.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner_idx  = IDX_W'(idx);
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer pixel write port between
// NUM_REQ drawers, with bounded bursts per grant tenure.
// Optional macro PIXEL_ARB_STATS_EN adds per-requester saturating
// accepted-write counters (stats_clr / write_count).
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fb_ready,
  output logic                       fb_we,
  output logic [X_W-1:0]             fb_x,
  output logic [Y_W-1:0]             fb_y,
  output logic [COLOR_W-1:0]         fb_color
`ifdef PIXEL_ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [NUM_REQ*STAT_W-1:0]  write_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;

  logic                 busy, own_req, accept, at_limit, release_now;
  logic [IDX_W-1:0]     ptr_after, pick_ptr, pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_valid;

  logic [X_W-1:0]       x_slice     [NUM_REQ];
  logic [Y_W-1:0]       y_slice     [NUM_REQ];
  logic [COLOR_W-1:0]   color_slice [NUM_REQ];

  // Unpack the per-requester pixel buses so the owner index can select them.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_slice[gi]     = req_x[gi*X_W +: X_W];
    assign y_slice[gi]     = req_y[gi*Y_W +: Y_W];
    assign color_slice[gi] = req_color[gi*COLOR_W +: COLOR_W];
  end

  assign busy     = (state_reg == BUSY);
  assign own_req  = busy & req[owner_reg];
  assign accept   = own_req & fb_ready & ~reset;
  // A stalled write never reaches the limit: only an accepted write counts.
  assign at_limit = accept & (count_reg == LAST_CNT);
  assign release_now = busy & (~req[owner_reg] | at_limit);

  // On release the search starts just after the owner, so the owner is the
  // last candidate and is re-granted only if nobody else is asking.
  assign ptr_after = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
  assign pick_ptr  = busy ? ptr_after : ptr_reg;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .ptr        (pick_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Write port outputs: the block never stores pixel data, it muxes the owner.
  assign gnt      = gnt_reg;
  assign fb_we    = own_req & ~reset;
  assign ack      = accept ? gnt_reg : '0;
  assign fb_x     = busy ? x_slice[owner_reg]     : '0;
  assign fb_y     = busy ? y_slice[owner_reg]     : '0;
  assign fb_color = busy ? color_slice[owner_reg] : '0;

  // Next-state logic: grant from IDLE, release/hand-over or count in BUSY.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          owner_next = pick_idx;
          gnt_next   = pick_onehot;
          count_next = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_next   = ptr_after;
          count_next = '0;
          if (pick_valid) begin
            owner_next = pick_idx;
            gnt_next   = pick_onehot;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (accept) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      count_reg <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      gnt_reg   <= gnt_next;
    end
  end

`ifdef PIXEL_ARB_STATS_EN
  // One saturating accepted-write counter per requester; clear beats ack.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [STAT_W-1:0] wc_reg;
    always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
        wc_reg <= '0;
      end else if (ack[gi] && (wc_reg != '1)) begin
        wc_reg <= wc_reg + STAT_W'(1);
      end
    end
    assign write_count[gi*STAT_W +: STAT_W] = wc_reg;
  end
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: the driver pushes expected
// per-cycle outputs from a behavioural model; a negedge monitor compares.
module tb_pixel_write_arbiter;
  import pixel_arb_pkg::*;

  localparam int N  = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 1;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*CW-1:0] req_color;
  logic [N-1:0]    ack, gnt;
  logic            fb_ready, fb_we;
  logic [XW-1:0]   fb_x;
  logic [YW-1:0]   fb_y;
  logic [CW-1:0]   fb_color;
`ifdef PIXEL_ARB_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] write_count;
`endif

  pixel_write_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .ack(ack), .gnt(gnt), .fb_ready(fb_ready),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color)
`ifdef PIXEL_ARB_STATS_EN
    , .stats_clr(stats_clr), .write_count(write_count)
`endif
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          we;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   quiet = 1'b0;

  // Requester pixel data (advances after each acknowledged write).
  int px[N], py[N], pc[N];
  // Reference model: owner (-1 = none), round-robin pointer, burst count.
  int m_owner = -1;
  int m_ptr = 0;
  int m_count = 0;
  int m_stat[N];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic new_pixel(input int i);
    px[i] = int'($urandom_range(0, 639));
    py[i] = int'($urandom_range(0, 479));
    pc[i] = int'($urandom_range(0, 1));
  endtask

  // Drive one cycle, push its expected outputs, advance the model.
  task automatic step(input logic [N-1:0] r, input logic rdy, input logic rst,
                      output logic [N-1:0] exp_ack);
    obs_t e;
    bit   took;
    req = r; fb_ready = rdy; reset = rst;
    for (int i = 0; i < N; i++) begin
      req_x[i*XW +: XW]     = XW'(px[i]);
      req_y[i*YW +: YW]     = YW'(py[i]);
      req_color[i*CW +: CW] = CW'(pc[i]);
    end
    e = '0;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.x  = XW'(px[m_owner]);
      e.y  = YW'(py[m_owner]);
      e.c  = CW'(pc[m_owner]);
      e.we = r[m_owner] && !rst;
      if (r[m_owner] && rdy && !rst) e.ack[m_owner] = 1'b1;
    end
    exp_q.push_back(e);
    exp_ack = e.ack;
    took = (e.ack != '0);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_count = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
    end else if (!r[m_owner] || (took && m_count == MB - 1)) begin
      m_ptr = (m_owner + 1) % N;
      m_count = 0;
      m_owner = pick(r, m_ptr);
    end else if (took) begin
      m_count++;
    end
    for (int i = 0; i < N; i++) begin
`ifdef PIXEL_ARB_STATS_EN
      if (rst || stats_clr) m_stat[i] = 0;
      else if (e.ack[i] && m_stat[i] < 65535) m_stat[i]++;
`else
      if (rst) m_stat[i] = 0;
      else if (e.ack[i]) m_stat[i]++;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (e.ack[i]) new_pixel(i);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, ack, fb_we, fb_x, fb_y, fb_color};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cyc %0d: got gnt=%b ack=%b we=%b x=%0d y=%0d c=%0d, expected gnt=%b ack=%b we=%b x=%0d y=%0d c=%0d",
                 cyc, a.gnt, a.ack, a.we, a.x, a.y, a.c, e.gnt, e.ack, e.we, e.x, e.y, e.c);
      end else if (e.ack != '0 && !quiet) begin
        $display("[TB] cyc %0d write ack=%b x=%0d y=%0d c=%0d", cyc, e.ack, e.x, e.y, e.c);
      end
    end
  end

`ifdef PIXEL_ARB_STATS_EN
  task automatic check_stats(input string name);
    for (int i = 0; i < N; i++) begin
      tests++;
      if (int'(write_count[i*16 +: 16]) != m_stat[i]) begin
        fails++;
        $display("FAIL %s req%0d: write_count=%0d expected %0d", name, i,
                 write_count[i*16 +: 16], m_stat[i]);
      end
    end
  endtask
`endif

  initial begin
    logic [N-1:0] ea;
    logic [N-1:0] r;
    bit           active[N];
    reset = 1'b1; req = '0; fb_ready = 1'b1;
    req_x = '0; req_y = '0; req_color = '0;
`ifdef PIXEL_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin new_pixel(i); m_stat[i] = 0; end
    @(posedge clk); #1;

    // Reset state.
    repeat (2) step(2'b00, 1'b1, 1'b1, ea);

    // Single requester with a known pixel.
    px[0] = 100; py[0] = 50; pc[0] = 1;
    step(2'b01, 1'b1, 1'b0, ea);
    step(2'b01, 1'b1, 1'b0, ea);
    repeat (2) step(2'b00, 1'b1, 1'b0, ea);

    // Contention: bursts of MB alternate without bubbles.
    step(2'b00, 1'b1, 1'b1, ea);
    repeat (20) step(2'b11, 1'b1, 1'b0, ea);
    step(2'b00, 1'b1, 1'b0, ea);

    // Stall at count 7 of 8, then one more ack and hand-over.
    step(2'b00, 1'b1, 1'b1, ea);
    repeat (8) step(2'b11, 1'b1, 1'b0, ea);
    repeat (5) step(2'b11, 1'b0, 1'b0, ea);
    repeat (4) step(2'b11, 1'b1, 1'b0, ea);
    step(2'b00, 1'b1, 1'b0, ea);

    // Owner drops after 3 acks while requester 1 waits.
    step(2'b00, 1'b1, 1'b1, ea);
    repeat (4) step(2'b11, 1'b1, 1'b0, ea);
    repeat (3) step(2'b10, 1'b1, 1'b0, ea);
    step(2'b01, 1'b1, 1'b0, ea);
    step(2'b01, 1'b1, 1'b0, ea);
    step(2'b00, 1'b1, 1'b0, ea);

    // Reset mid-burst.
    repeat (3) step(2'b11, 1'b1, 1'b0, ea);
    step(2'b11, 1'b1, 1'b1, ea);
    repeat (2) step(2'b11, 1'b1, 1'b0, ea);
    step(2'b00, 1'b1, 1'b0, ea);

    // Randomized traffic: requesters hold req until acked.
    for (int i = 0; i < N; i++) active[i] = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) r[i] = active[i];
      step(r, ($urandom % 5) != 0, ($urandom % 200) == 0, ea);
      for (int i = 0; i < N; i++) begin
        if (ea[i] && ($urandom % 4) == 0) active[i] = 1'b0;
        else if (!active[i] && ($urandom % 3) == 0) active[i] = 1'b1;
      end
    end
    step(2'b00, 1'b1, 1'b0, ea);

`ifdef PIXEL_ARB_STATS_EN
    check_stats("stats_random");
    quiet = 1'b1;
    repeat (70000) step(2'b01, 1'b1, 1'b0, ea);
    quiet = 1'b0;
    check_stats("stats_saturate");
    stats_clr = 1'b1;
    step(2'b01, 1'b1, 1'b0, ea);
    stats_clr = 1'b0;
    check_stats("stats_clear");
    step(2'b00, 1'b1, 1'b0, ea);
`endif

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
